// File: rtl/pdts_pll_lock_sequencer.sv
// Reset/lock supervisor for N_CH PLLs on a shared reference clock.
// Optional lock watchdog is enabled by defining PDTS_PLL_SEQ_TIMEOUT_EN.
module pdts_pll_lock_sequencer #(
  parameter int N_CH           = 1,
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 8
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         pll_locked_in,
  input  logic [N_CH-1:0]         force_rst,
  output logic [N_CH-1:0]         pll_rst,
  output logic [N_CH-1:0]         ch_ready,
  output logic                    all_ready,
  output logic [2*N_CH-1:0]       ch_state,
  output logic [CNT_W*N_CH-1:0]   loss_cnt
);

  localparam int RST_W = $clog2(RST_CYCLES);
  localparam int STB_W = $clog2(STABLE_CYCLES);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
`ifdef PDTS_PLL_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_RESET     = 2'b00,
    ST_WAIT_LOCK = 2'b01,
    ST_STABLE    = 2'b10,
    ST_READY     = 2'b11
  } state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]       sync_q;
    logic             lk;
    state_t           state_q, state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             prst_q;
    logic             ready_q;
    logic             restart;

    // Two-flop synchroniser for the asynchronous locked flag.
    always_ff @(posedge refclk) begin
      if (!rst_n) begin
        sync_q <= 2'b00;
      end else begin
        sync_q <= {sync_q[0], pll_locked_in[i]};
      end
    end

    assign lk = sync_q[1];

`ifdef PDTS_PLL_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] wd_q, wd_d;
    logic            in_lock_wait;
    logic            timeout;

    assign in_lock_wait = (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE);
    assign timeout      = in_lock_wait && (wd_q == TO_LAST);
    assign restart      = force_rst[i] | timeout;
`else
    assign restart      = force_rst[i];
`endif

    always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      stb_cnt_d = stb_cnt_q;
      loss_d    = loss_q;
`ifdef PDTS_PLL_SEQ_TIMEOUT_EN
      wd_d      = '0;
`endif
      if (restart) begin
        // Forced or timed-out re-reset restarts the window and never counts as a loss.
        state_d   = ST_RESET;
        rst_cnt_d = '0;
        stb_cnt_d = '0;
      end else begin
        case (state_q)
          ST_RESET: begin
            if (rst_cnt_q == RST_LAST) begin
              rst_cnt_d = '0;
              state_d   = ST_WAIT_LOCK;
            end else begin
              rst_cnt_d = rst_cnt_q + 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            if (lk) begin
              stb_cnt_d = '0;
              state_d   = ST_STABLE;
            end
          end
          ST_STABLE: begin
            if (!lk) begin
              state_d = ST_WAIT_LOCK;
            end else if (stb_cnt_q == STB_LAST) begin
              stb_cnt_d = '0;
              state_d   = ST_READY;
            end else begin
              stb_cnt_d = stb_cnt_q + 1'b1;
            end
          end
          ST_READY: begin
            if (!lk) begin
              rst_cnt_d = '0;
              state_d   = ST_RESET;
              if (loss_q != {CNT_W{1'b1}}) begin
                loss_d = loss_q + 1'b1;
              end
            end
          end
          default: state_d = ST_RESET;
        endcase
      end
`ifdef PDTS_PLL_SEQ_TIMEOUT_EN
      // Watchdog spans WAIT_LOCK and STABLE together; any other entry clears it.
      if (in_lock_wait && ((state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE))) begin
        wd_d = wd_q + 1'b1;
      end
`endif
    end

    always_ff @(posedge refclk) begin
      if (!rst_n) begin
        state_q   <= ST_RESET;
        rst_cnt_q <= '0;
        stb_cnt_q <= '0;
        loss_q    <= '0;
        prst_q    <= 1'b1;
        ready_q   <= 1'b0;
      end else begin
        state_q   <= state_d;
        rst_cnt_q <= rst_cnt_d;
        stb_cnt_q <= stb_cnt_d;
        loss_q    <= loss_d;
        prst_q    <= (state_d == ST_RESET);
        ready_q   <= (state_d == ST_READY);
      end
    end

`ifdef PDTS_PLL_SEQ_TIMEOUT_EN
    always_ff @(posedge refclk) begin
      if (!rst_n) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_d;
      end
    end
`endif

    assign pll_rst[i]                   = prst_q;
    assign ch_ready[i]                  = ready_q;
    assign ch_state[2*i +: 2]           = state_q;
    assign loss_cnt[CNT_W*i +: CNT_W]   = loss_q;
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      all_ready <= 1'b0;
    end else begin
      all_ready <= &ch_ready;
    end
  end

endmodule

// File: tb/tb_pdts_pll_lock_sequencer.sv
// Directed bench for pdts_pll_lock_sequencer: edge-tagged expectations are
// queued by the stimulus and compared by an independent negedge monitor.
module tb_pdts_pll_lock_sequencer;

  localparam int N_CH = 2;
  localparam int CNT_W = 2;
  localparam int W = 13;

  logic                  refclk;
  logic                  rst_n;
  logic [N_CH-1:0]       pll_locked_in;
  logic [N_CH-1:0]       force_rst;
  logic [N_CH-1:0]       pll_rst;
  logic [N_CH-1:0]       ch_ready;
  logic                  all_ready;
  logic [2*N_CH-1:0]     ch_state;
  logic [CNT_W*N_CH-1:0] loss_cnt;

  pdts_pll_lock_sequencer #(
    .N_CH(N_CH), .RST_CYCLES(4), .STABLE_CYCLES(8),
    .TIMEOUT_CYCLES(32), .CNT_W(CNT_W)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked_in(pll_locked_in),
    .force_rst(force_rst), .pll_rst(pll_rst), .ch_ready(ch_ready),
    .all_ready(all_ready), .ch_state(ch_state), .loss_cnt(loss_cnt)
  );

  // clock / reset / edge counter
  int edge_n = 0;
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;
  always @(posedge refclk) edge_n <= edge_n + 1;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] obs;

  function automatic logic [W-1:0] v(logic [1:0] prst, logic [1:0] rdy, logic all,
                                     logic [3:0] st, logic [3:0] ls);
    return {prst, rdy, all, st, ls};
  endfunction

  task automatic chk(input int at, input string nm, input logic [W-1:0] e);
    cyc_q.push_back(at);
    exp_q.push_back(e);
    tag_q.push_back(nm);
  endtask

  always @(negedge refclk) begin
    obs = {pll_rst, ch_ready, all_ready, ch_state, loss_cnt};
    while (cyc_q.size() > 0 && cyc_q[0] <= edge_n) begin
      int c;
      logic [W-1:0] e;
      string t;
      c = cyc_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (c != edge_n) begin
        failures++;
        $display("FAIL %s check scheduled for edge %0d reached only at edge %0d", t, c, edge_n);
      end else if (obs !== e) begin
        failures++;
        $display("FAIL %s edge=%0d actual(prst,rdy,all,st,loss)=%b required=%b", t, edge_n, obs, e);
      end
    end
  end

  // driver tasks
  task automatic run_to(input int e);
    while (edge_n < e) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic drop_lock(input int at, input logic [1:0] val);
    run_to(at);
    pll_locked_in = val;
    run_to(at + 1);
    pll_locked_in = 2'b11;
  endtask

  task automatic pulse_force(input int at, input logic [1:0] val);
    run_to(at);
    force_rst = val;
    run_to(at + 1);
    force_rst = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    pll_locked_in = 2'b11;
    force_rst = 2'b00;

    // power-up: reset for edges 1..5, first high sample at edge 6
    chk(5,  "reset_vals",    v(2'b11, 2'b00, 1'b0, 4'b0000, 4'b0000));
    chk(8,  "rst_window",    v(2'b11, 2'b00, 1'b0, 4'b0000, 4'b0000));
    chk(9,  "wait_lock",     v(2'b00, 2'b00, 1'b0, 4'b0101, 4'b0000));
    chk(10, "stable",        v(2'b00, 2'b00, 1'b0, 4'b1010, 4'b0000));
    chk(17, "stable_end",    v(2'b00, 2'b00, 1'b0, 4'b1010, 4'b0000));
    chk(18, "ready_lat",     v(2'b00, 2'b11, 1'b0, 4'b1111, 4'b0000));
    chk(19, "all_ready",     v(2'b00, 2'b11, 1'b1, 4'b1111, 4'b0000));
    run_to(5);
    rst_n = 1'b1;

    // single-cycle lock loss on channel 0
    chk(22, "loss_sync_lat", v(2'b00, 2'b11, 1'b1, 4'b1111, 4'b0000));
    chk(23, "loss_reset",    v(2'b01, 2'b10, 1'b1, 4'b1100, 4'b0001));
    chk(24, "all_drop",      v(2'b01, 2'b10, 1'b0, 4'b1100, 4'b0001));
    chk(27, "loss_rst_end",  v(2'b00, 2'b10, 1'b0, 4'b1101, 4'b0001));
    chk(35, "relock_stable", v(2'b00, 2'b10, 1'b0, 4'b1110, 4'b0001));
    chk(36, "relock_ready",  v(2'b00, 2'b11, 1'b0, 4'b1111, 4'b0001));
    chk(37, "relock_all",    v(2'b00, 2'b11, 1'b1, 4'b1111, 4'b0001));
    drop_lock(20, 2'b10);

    // four more losses: counter saturates at 3
    for (int t = 0; t < 4; t++) begin
      int base;
      logic [1:0] lc;
      base = 40 + 20 * t;
      lc = (t == 0) ? 2'd2 : 2'd3;
      chk(base + 3, "loss_sat", v(2'b01, 2'b10, 1'b1, 4'b1100, {2'b00, lc}));
      drop_lock(base, 2'b10);
    end
    chk(117, "sat_ready",    v(2'b00, 2'b11, 1'b1, 4'b1111, 4'b0011));

    // force ch1, then lose lock during STABLE after 5 stable cycles
    chk(121, "force_ch1",    v(2'b10, 2'b01, 1'b1, 4'b0011, 4'b0011));
    chk(124, "force1_win",   v(2'b10, 2'b01, 1'b0, 4'b0011, 4'b0011));
    chk(125, "force1_wait",  v(2'b00, 2'b01, 1'b0, 4'b0111, 4'b0011));
    chk(126, "force1_stab",  v(2'b00, 2'b01, 1'b0, 4'b1011, 4'b0011));
    chk(132, "stable_loss",  v(2'b00, 2'b01, 1'b0, 4'b0111, 4'b0011));
    chk(133, "stable_again", v(2'b00, 2'b01, 1'b0, 4'b1011, 4'b0011));
    chk(140, "full_relock",  v(2'b00, 2'b01, 1'b0, 4'b1011, 4'b0011));
    chk(141, "relock1_rdy",  v(2'b00, 2'b11, 1'b0, 4'b1111, 4'b0011));
    chk(142, "relock1_all",  v(2'b00, 2'b11, 1'b1, 4'b1111, 4'b0011));
    pulse_force(120, 2'b10);
    drop_lock(129, 2'b01);

    // force ch0 from READY
    chk(151, "force_ch0",    v(2'b01, 2'b10, 1'b1, 4'b1100, 4'b0011));
    chk(154, "force0_win",   v(2'b01, 2'b10, 1'b0, 4'b1100, 4'b0011));
    chk(155, "force0_wait",  v(2'b00, 2'b10, 1'b0, 4'b1101, 4'b0011));
    chk(165, "force0_all",   v(2'b00, 2'b11, 1'b1, 4'b1111, 4'b0011));
    pulse_force(150, 2'b01);

    // force while already in RESET restarts the window
    chk(171, "restart_a",    v(2'b01, 2'b10, 1'b1, 4'b1100, 4'b0011));
    chk(176, "restart_hold", v(2'b01, 2'b10, 1'b0, 4'b1100, 4'b0011));
    chk(177, "restart_wait", v(2'b00, 2'b10, 1'b0, 4'b1101, 4'b0011));
    chk(187, "restart_all",  v(2'b00, 2'b11, 1'b1, 4'b1111, 4'b0011));
    pulse_force(170, 2'b01);
    pulse_force(172, 2'b01);

    // rst_n low together with force_rst: full reset wins
    chk(191, "rst_vs_force", v(2'b11, 2'b00, 1'b0, 4'b0000, 4'b0000));
    chk(194, "rst2_window",  v(2'b11, 2'b00, 1'b0, 4'b0000, 4'b0000));
    chk(204, "rst2_ready",   v(2'b00, 2'b11, 1'b0, 4'b1111, 4'b0000));
    chk(205, "rst2_all",     v(2'b00, 2'b11, 1'b1, 4'b1111, 4'b0000));
    run_to(190);
    force_rst = 2'b01;
    rst_n = 1'b0;
    run_to(191);
    force_rst = 2'b00;
    rst_n = 1'b1;

    // simultaneous loss on both channels
    chk(213, "dual_loss",    v(2'b11, 2'b00, 1'b1, 4'b0000, 4'b0101));
    chk(226, "dual_ready",   v(2'b00, 2'b11, 1'b0, 4'b1111, 4'b0101));
    chk(227, "dual_all",     v(2'b00, 2'b11, 1'b1, 4'b1111, 4'b0101));
    drop_lock(210, 2'b00);

    // lock held low: watchdog behaviour
    chk(233, "nolock_loss",  v(2'b11, 2'b00, 1'b1, 4'b0000, 4'b1010));
    chk(237, "nolock_wait",  v(2'b00, 2'b00, 1'b0, 4'b0101, 4'b1010));
    chk(268, "wd_pre",       v(2'b00, 2'b00, 1'b0, 4'b0101, 4'b1010));
`ifdef PDTS_PLL_SEQ_TIMEOUT_EN
    chk(269, "wd_fire",      v(2'b11, 2'b00, 1'b0, 4'b0000, 4'b1010));
    chk(273, "wd_rewait",    v(2'b00, 2'b00, 1'b0, 4'b0101, 4'b1010));
    chk(305, "wd_fire2",     v(2'b11, 2'b00, 1'b0, 4'b0000, 4'b1010));
`else
    chk(269, "wait_forever", v(2'b00, 2'b00, 1'b0, 4'b0101, 4'b1010));
    chk(305, "wait_forever2", v(2'b00, 2'b00, 1'b0, 4'b0101, 4'b1010));
`endif
    run_to(230);
    pll_locked_in = 2'b00;
    run_to(310);

    // final report
    for (int k = 0; k < 20 && cyc_q.size() > 0; k++) begin
      @(posedge refclk);
    end
    if (cyc_q.size() > 0) begin
      failures += cyc_q.size();
      $display("FAIL drain %0d expectations never compared", cyc_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
